// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: per-boundary bundle widths, control-field
// bit positions, slot operation codes and the occupancy encoding reported on count_o.
package pipe_pkg;

  localparam int unsigned IF_ID_CTRL_W  = 8;
  localparam int unsigned IF_ID_DATA_W  = 64;
  localparam int unsigned ID_EX_CTRL_W  = 8;
  localparam int unsigned ID_EX_DATA_W  = 143;
  localparam int unsigned EX_MEM_CTRL_W = 5;
  localparam int unsigned EX_MEM_DATA_W = 106;
  localparam int unsigned MEM_WB_CTRL_W = 2;
  localparam int unsigned MEM_WB_DATA_W = 69;

  localparam int unsigned CTRL_REG_WRITE = 0;
  localparam int unsigned CTRL_MEM_TO_REG = 1;
  localparam int unsigned CTRL_MEM_READ  = 2;
  localparam int unsigned CTRL_MEM_WRITE = 3;
  localparam int unsigned CTRL_ALU_OP_LSB = 4;
  localparam int unsigned CTRL_ALU_OP_W  = 2;
  localparam int unsigned CTRL_ALU_SRC   = 6;
  localparam int unsigned CTRL_BRANCH    = 7;

  typedef enum logic [1:0] {
    SLOT_HOLD      = 2'd0,
    SLOT_LOAD_IN   = 2'd1,
    SLOT_LOAD_SKID = 2'd2,
    SLOT_CLEAR     = 2'd3
  } slot_op_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_MAIN  = 2'd1,
    OCC_BOTH  = 2'd2
  } occ_e;

  // The skid slot is only ever filled while main is full, so skid-only is unreachable.
  function automatic occ_e occ_of(input logic main_v, input logic skid_v);
    if (main_v && skid_v) begin
      return OCC_BOTH;
    end else if (main_v || skid_v) begin
      return OCC_MAIN;
    end
    return OCC_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One pipeline entry: valid + control + payload register with load and clear.
// Clear drops valid and control but keeps the payload so the datapath does not toggle.
module pipe_skid_slot #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 143
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_d, valid_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DATA_W-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Parametrised pipeline-stage register with valid/ready, stall, flush and bubble,
// optionally backed by a skid entry so that in_ready_o comes straight from a flop.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 143,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              bubble_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        count_o
);

  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
  logic [DATA_W-1:0] main_data, skid_data, main_data_in;
  logic              accept, emit, main_free;
  slot_op_e          main_op, skid_op;

  // Skid contents take precedence over upstream when main frees up; the upstream
  // cannot be accepted in that cycle anyway because in_ready_o is low.
  always_comb begin
    accept    = in_valid_i & in_ready_o & ~bubble_i & ~stall_i & ~flush_i;
    emit      = main_valid & out_ready_i & ~stall_i & ~flush_i;
    main_free = ~main_valid | emit;
    main_op   = SLOT_HOLD;
    skid_op   = SLOT_HOLD;
    if (flush_i) begin
      main_op = SLOT_CLEAR;
      skid_op = SLOT_CLEAR;
    end else if (!stall_i) begin
      if (main_free) begin
        if (skid_valid) begin
          main_op = SLOT_LOAD_SKID;
          skid_op = SLOT_CLEAR;
        end else if (accept) begin
          main_op = SLOT_LOAD_IN;
        end else begin
          main_op = SLOT_CLEAR;
        end
      end else if (accept) begin
        skid_op = SLOT_LOAD_IN;
      end
    end
  end

  always_comb begin
    main_ctrl_in = in_ctrl_i;
    main_data_in = in_data_i;
    if (main_op == SLOT_LOAD_SKID) begin
      main_ctrl_in = skid_ctrl;
      main_data_in = skid_data;
    end
  end

  pipe_skid_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  ((main_op == SLOT_LOAD_IN) || (main_op == SLOT_LOAD_SKID)),
    .clear_i (main_op == SLOT_CLEAR),
    .ctrl_i  (main_ctrl_in),
    .data_i  (main_data_in),
    .valid_o (main_valid),
    .ctrl_o  (main_ctrl),
    .data_o  (main_data)
  );

  if (SKID != 0) begin : g_skid
    pipe_skid_slot #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
    ) u_skid (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (skid_op == SLOT_LOAD_IN),
      .clear_i (skid_op == SLOT_CLEAR),
      .ctrl_i  (in_ctrl_i),
      .data_i  (in_data_i),
      .valid_o (skid_valid),
      .ctrl_o  (skid_ctrl),
      .data_o  (skid_data)
    );
    assign in_ready_o = ~skid_valid;
  end else begin : g_no_skid
    logic unused_skid_op;
    assign skid_valid     = 1'b0;
    assign skid_ctrl      = '0;
    assign skid_data      = '0;
    assign unused_skid_op = ^skid_op;
    assign in_ready_o     = (~main_valid | out_ready_i) & ~stall_i & ~bubble_i;
  end

  assign out_valid_o = main_valid;
  assign out_ctrl_o  = main_valid ? main_ctrl : '0;
  assign out_data_o  = main_data;
  assign count_o     = occ_of(main_valid, skid_valid);

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a SKID=1 instance and a SKID=0 instance share
// the same stimulus; each task checks one behaviour against hand-derived values.
module tb_pipe_stage_buf;

  localparam int unsigned CW = 8;
  localparam int unsigned DW = 16;

  logic          clk, rst_n, stall, flush, bubble, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          in_ready1, out_valid1, in_ready0, out_valid0;
  logic [CW-1:0] out_ctrl1, out_ctrl0;
  logic [DW-1:0] out_data1, out_data0;
  logic [1:0]    count1, count0;
  logic [26:0]   obs1, obs0;

  int unsigned errors = 0;
  int unsigned checks = 0;

  pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n), .stall_i(stall), .flush_i(flush), .bubble_i(bubble),
    .in_valid_i(in_valid), .in_ready_o(in_ready1), .in_ctrl_i(in_ctrl), .in_data_i(in_data),
    .out_valid_o(out_valid1), .out_ready_i(out_ready), .out_ctrl_o(out_ctrl1),
    .out_data_o(out_data1), .count_o(count1)
  );

  pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst_n), .stall_i(stall), .flush_i(flush), .bubble_i(bubble),
    .in_valid_i(in_valid), .in_ready_o(in_ready0), .in_ctrl_i(in_ctrl), .in_data_i(in_data),
    .out_valid_o(out_valid0), .out_ready_i(out_ready), .out_ctrl_o(out_ctrl0),
    .out_data_o(out_data0), .count_o(count0)
  );

  assign obs1 = {out_valid1, out_ctrl1, out_data1, count1};
  assign obs0 = {out_valid0, out_ctrl0, out_data0, count0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CW-1:0] ctrl_of(input logic [DW-1:0] d);
    return d[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [26:0] exp_of(input logic v, input logic [DW-1:0] d, input logic [1:0] c);
    return {v, (v ? ctrl_of(d) : 8'h00), d, c};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d);
    in_valid = v;
    in_data  = d;
    in_ctrl  = ctrl_of(d);
  endtask

  task automatic do_reset;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; bubble = 1'b0; out_ready = 1'b0;
    drive(1'b1, 16'h0005);
    tick;
    tick;
    rst_n = 1'b1;
    drive(1'b0, 16'h0000);
  endtask

  task automatic test_reset;
    logic [26:0] e;
    do_reset;
    e = exp_of(1'b0, 16'h0000, 2'd0);
    checks++;
    if (obs1 !== e) begin errors++; $display("FAIL reset_s1 got=%h exp=%h", obs1, e); end
    checks++;
    if (obs0 !== e) begin errors++; $display("FAIL reset_s0 got=%h exp=%h", obs0, e); end
    tick;
    checks++;
    if ({in_ready1, in_ready0} !== 2'b11) begin
      errors++; $display("FAIL reset_ready got=%b exp=11", {in_ready1, in_ready0});
    end
  endtask

  task automatic test_stream;
    logic [26:0] e;
    do_reset;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 16'(i));
      tick;
      e = exp_of(1'b1, 16'(i), 2'd1);
      checks++;
      if (obs1 !== e) begin errors++; $display("FAIL stream_s1_%0d got=%h exp=%h", i, obs1, e); end
      checks++;
      if (obs0 !== e) begin errors++; $display("FAIL stream_s0_%0d got=%h exp=%h", i, obs0, e); end
    end
    drive(1'b0, 16'h0000);
    tick;
    e = exp_of(1'b0, 16'h0004, 2'd0);
    checks++;
    if (obs1 !== e) begin errors++; $display("FAIL stream_drain got=%h exp=%h", obs1, e); end
  endtask

  task automatic test_backpressure;
    logic [26:0] e;
    do_reset;
    drive(1'b1, 16'h000A);
    tick;
    drive(1'b1, 16'h000B);
    tick;
    e = exp_of(1'b1, 16'h000A, 2'd2);
    checks++;
    if ({obs1, in_ready1} !== {e, 1'b0}) begin
      errors++; $display("FAIL bp_full got=%h exp=%h", {obs1, in_ready1}, {e, 1'b0});
    end
    drive(1'b1, 16'h000C);
    tick;
    checks++;
    if (obs1 !== e) begin errors++; $display("FAIL bp_hold got=%h exp=%h", obs1, e); end
    drive(1'b0, 16'h0000);
    out_ready = 1'b1;
    tick;
    e = exp_of(1'b1, 16'h000B, 2'd1);
    checks++;
    if ({obs1, in_ready1} !== {e, 1'b1}) begin
      errors++; $display("FAIL bp_skid_out got=%h exp=%h", {obs1, in_ready1}, {e, 1'b1});
    end
    tick;
    e = exp_of(1'b0, 16'h000B, 2'd0);
    checks++;
    if (obs1 !== e) begin errors++; $display("FAIL bp_empty got=%h exp=%h", obs1, e); end
  endtask

  task automatic test_stall;
    logic [26:0] e;
    do_reset;
    drive(1'b1, 16'h000A);
    tick;
    drive(1'b1, 16'h000C);
    stall     = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if ({in_ready1, in_ready0} !== 2'b10) begin
      errors++; $display("FAIL stall_ready got=%b exp=10", {in_ready1, in_ready0});
    end
    e = exp_of(1'b1, 16'h000A, 2'd1);
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (obs1 !== e) begin errors++; $display("FAIL stall_s1_%0d got=%h exp=%h", i, obs1, e); end
      checks++;
      if (obs0 !== e) begin errors++; $display("FAIL stall_s0_%0d got=%h exp=%h", i, obs0, e); end
    end
    stall = 1'b0;
    tick;
    e = exp_of(1'b1, 16'h000C, 2'd1);
    checks++;
    if (obs1 !== e) begin errors++; $display("FAIL stall_rel_s1 got=%h exp=%h", obs1, e); end
    checks++;
    if (obs0 !== e) begin errors++; $display("FAIL stall_rel_s0 got=%h exp=%h", obs0, e); end
  endtask

  task automatic test_flush;
    logic [26:0] e;
    do_reset;
    drive(1'b1, 16'h000A);
    tick;
    drive(1'b1, 16'h000B);
    tick;
    flush = 1'b1;
    drive(1'b1, 16'h000D);
    tick;
    e = exp_of(1'b0, 16'h000A, 2'd0);
    checks++;
    if (obs1 !== e) begin errors++; $display("FAIL flush_s1 got=%h exp=%h", obs1, e); end
    checks++;
    if (obs0 !== e) begin errors++; $display("FAIL flush_s0 got=%h exp=%h", obs0, e); end
    flush = 1'b0;
    drive(1'b0, 16'h0000);
    #1;
    checks++;
    if (in_ready1 !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", in_ready1); end
    tick;
    checks++;
    if (obs1 !== e) begin errors++; $display("FAIL flush_after got=%h exp=%h", obs1, e); end
  endtask

  task automatic test_bubble;
    logic [26:0] e;
    do_reset;
    out_ready = 1'b1;
    drive(1'b1, 16'h000A);
    tick;
    bubble = 1'b1;
    drive(1'b1, 16'h000C);
    #1;
    checks++;
    if (in_ready0 !== 1'b0) begin errors++; $display("FAIL bubble_ready0 got=%b exp=0", in_ready0); end
    tick;
    e = exp_of(1'b0, 16'h000A, 2'd0);
    checks++;
    if (obs1 !== e) begin errors++; $display("FAIL bubble_s1 got=%h exp=%h", obs1, e); end
    checks++;
    if (obs0 !== e) begin errors++; $display("FAIL bubble_s0 got=%h exp=%h", obs0, e); end
    bubble = 1'b0;
    tick;
    e = exp_of(1'b1, 16'h000C, 2'd1);
    checks++;
    if (obs1 !== e) begin errors++; $display("FAIL bubble_next_s1 got=%h exp=%h", obs1, e); end
    checks++;
    if (obs0 !== e) begin errors++; $display("FAIL bubble_next_s0 got=%h exp=%h", obs0, e); end
  endtask

  task automatic test_bubble_drain;
    logic [26:0] e;
    do_reset;
    drive(1'b1, 16'h000A);
    tick;
    drive(1'b1, 16'h000B);
    tick;
    bubble    = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 16'h000C);
    tick;
    e = exp_of(1'b1, 16'h000B, 2'd1);
    checks++;
    if ({obs1, in_ready1} !== {e, 1'b1}) begin
      errors++; $display("FAIL bdrain_skid got=%h exp=%h", {obs1, in_ready1}, {e, 1'b1});
    end
    bubble = 1'b0;
    tick;
    e = exp_of(1'b1, 16'h000C, 2'd1);
    checks++;
    if (obs1 !== e) begin errors++; $display("FAIL bdrain_next got=%h exp=%h", obs1, e); end
  endtask

  task automatic test_back_to_back;
    logic [26:0] e;
    do_reset;
    drive(1'b1, 16'h000A);
    tick;
    drive(1'b1, 16'h000B);
    tick;
    out_ready = 1'b1;
    drive(1'b1, 16'h000C);
    tick;
    e = exp_of(1'b1, 16'h000B, 2'd1);
    checks++;
    if (obs1 !== e) begin errors++; $display("FAIL b2b_skid got=%h exp=%h", obs1, e); end
    tick;
    e = exp_of(1'b1, 16'h000C, 2'd1);
    checks++;
    if (obs1 !== e) begin errors++; $display("FAIL b2b_c got=%h exp=%h", obs1, e); end
    drive(1'b1, 16'h000E);
    tick;
    e = exp_of(1'b1, 16'h000E, 2'd1);
    checks++;
    if (obs1 !== e) begin errors++; $display("FAIL b2b_e got=%h exp=%h", obs1, e); end
    drive(1'b0, 16'h0000);
    tick;
    e = exp_of(1'b0, 16'h000E, 2'd0);
    checks++;
    if (obs1 !== e) begin errors++; $display("FAIL b2b_empty got=%h exp=%h", obs1, e); end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; bubble = 1'b0; out_ready = 1'b0;
    drive(1'b0, 16'h0000);
    test_reset;
    test_stream;
    test_backpressure;
    test_stall;
    test_flush;
    test_bubble;
    test_bubble_drain;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
